fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline, directly upstream of HazardDetection.
//  Owns the PC and the IF/ID register, and drives the instruction memory over a req/ack handshake.
//  Applies HazardDetection's holdPC, IF_ID_Flush, isBranch and PC_offset, plus the ID-stage jump.
//  Discards responses to killed (wrong-path or refetched) requests.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INSTR  32'h0000_0000  instruction placed in IF/ID on reset/flush (sll $0,$0,0)
// PORTS
//  clk          in   1   single clock, all state on posedge
//  rst          in   1   synchronous, active-high reset
//  holdPC       in   1   load-use stall from HazardDetection
//  IF_ID_Flush  in   1   bubble IF/ID; drop word acked this cycle
//  isBranch     in   1   taken branch resolved in EX
//  PC_offset    in   32  sign-extended word offset of the EX branch
//  branch_pc4   in   32  PC+4 of the branch in EX (from ID/EX)
//  isJump       in   1   j in ID
//  jump_target  in   26  instr_index field of the j in ID
//  imem_req     out  1   fetch request
//  imem_addr    out  32  fetch address, word aligned
//  imem_ack     in   1   response valid, same cycle as req allowed
//  imem_rdata   in   32  fetched word, valid with imem_ack
//  instr_IF_ID  out  32  IF/ID instruction
//  pc4_IF_ID    out  32  IF/ID PC+4
//  valid_IF_ID  out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset values
//  - PC=RESET_PC, state=IDLE, imem_req=0.
//  - instr_IF_ID=NOP_INSTR, pc4_IF_ID=0, valid_IF_ID=0, redir_pc=0.
//  - rst mid-request: outstanding ack is ignored. IDLE holds req low one cycle after reset.
//  Targets (all arithmetic 32-bit, wrap modulo 2^32)
//  - br_tgt = branch_pc4 + (PC_offset<<2).
//  - j_tgt  = {pc4_IF_ID[31:28], jump_target, 2'b00}.
//  - Redirect priority, same cycle: isBranch > isJump (branch is the older instruction).
//  FSM
//  - IDLE -> REQ unconditionally.
//  - REQ: req=1, addr=PC.
//    - ack & !flush & !hold & !redirect: IF/ID<={rdata, PC+4, 1}; PC<=PC+4; stay REQ.
//      Back-to-back fetch gives 1 word/cycle with zero-wait memory.
//    - ack & redirect: drop word; PC<=target; stay REQ.
//    - ack & (hold|flush), no redirect: drop word; PC unchanged (refetch); stay REQ.
//    - !ack & redirect: redir_pc<=target; ->KILL.
//    - !ack otherwise: wait.
//  - KILL: req=1, addr=PC (old address, still outstanding).
//    - redirect: redir_pc<=target, newest wins.
//    - on ack: drop word; PC<=redir_pc (or the same-cycle target); ->REQ.
//  Handshake
//  - Once raised, req is held until ack.
//  - imem_addr is stable while req&!ack; it changes only in the cycle after an ack.
//  IF/ID update order: rst > IF_ID_Flush (bubble: NOP_INSTR, valid=0, pc4 kept) > accepted word > hold.
//  - A 1-cycle load-use stall therefore costs exactly one refetch of the held PC.
// STRUCTURE
//  fetch_pkg:
//  - typedef enum logic[1:0] {IDLE,REQ,KILL} fetch_state_t.
//  - NOP_INSTR default, WORD_BYTES=4.
//  Sub-module fetch_target_calc (combinational):
//  - Outputs br_tgt, j_tgt and redirect/target with branch>jump priority.
//  FSM, PC, redir_pc and IF/ID register stay in fetch_unit.
// TESTING
//  - Reset, zero-wait mem (ack=req): req high from cycle 2; addr 0,4,8,... each cycle;
//    pc4_IF_ID 4,8,12,...; valid_IF_ID=1.
//  - 2-cycle mem latency, isBranch=1, branch_pc4=0x20, PC_offset=-2, while waiting (no ack):
//    addr held until ack, word dropped, next addr=0x18.
//  - isBranch(br_tgt 0x40) with isJump(j_tgt 0x100) same cycle as ack:
//    next addr=0x40, IF/ID bubble (valid=0).
//  - holdPC=1 & IF_ID_Flush=1 for 1 cycle at addr 0x10: word dropped;
//    addr 0x10 reissued; IF/ID bubble then word@0x10.
//  - rst asserted while req outstanding, ack arrives during rst:
//    outputs at reset values; first post-reset addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES    = 32'd4;

endpackage

// File: rtl/fetch_target_calc.sv
// Redirect target computation for the IF stage; the EX branch beats the ID jump
// because the branch is the older instruction.
module fetch_target_calc (
    input  logic        isBranch,
    input  logic [31:0] PC_offset,
    input  logic [31:0] branch_pc4,
    input  logic        isJump,
    input  logic [25:0] jump_target,
    input  logic [3:0]  pc4_hi,
    output logic        redirect,
    output logic [31:0] target
);

    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    always_comb begin
        br_tgt   = branch_pc4 + (PC_offset << 2);
        j_tgt    = {pc4_hi, jump_target, 2'b00};
        redirect = isBranch | isJump;
        target   = isBranch ? br_tgt : j_tgt;
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, IF/ID register and instruction-memory req/ack handshake,
// with killing of responses that belong to wrong-path or refetched requests.
//
// state | meaning
// IDLE  | post-reset gap, req low
// REQ   | request at PC outstanding; an ack may be accepted
// KILL  | outstanding request is wrong-path; drop its ack, then go to redir_pc
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        holdPC,
    input  logic        IF_ID_Flush,
    input  logic        isBranch,
    input  logic [31:0] PC_offset,
    input  logic [31:0] branch_pc4,
    input  logic        isJump,
    input  logic [25:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_IF_ID,
    output logic [31:0] pc4_IF_ID,
    output logic        valid_IF_ID
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  redir_pc, redir_nxt;
    logic         accept;
    logic         redirect;
    logic [31:0]  target;

    fetch_target_calc u_target (
        .isBranch    (isBranch),
        .PC_offset   (PC_offset),
        .branch_pc4  (branch_pc4),
        .isJump      (isJump),
        .jump_target (jump_target),
        .pc4_hi      (pc4_IF_ID[31:28]),
        .redirect    (redirect),
        .target      (target)
    );

    assign imem_req  = (state != IDLE);
    assign imem_addr = pc;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        redir_nxt = redir_pc;
        accept    = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_nxt = target;
                    end else if (!IF_ID_Flush && !holdPC) begin
                        accept = 1'b1;
                        pc_nxt = pc + WORD_BYTES;
                    end
                end else if (redirect) begin
                    redir_nxt = target;
                    state_nxt = KILL;
                end
            end
            KILL: begin
                // The request stays outstanding at the old PC; only its ack frees us.
                if (redirect) begin
                    redir_nxt = target;
                end
                if (imem_ack) begin
                    pc_nxt    = redirect ? target : redir_pc;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            redir_pc    <= 32'd0;
            instr_IF_ID <= NOP_INSTR;
            pc4_IF_ID   <= 32'd0;
            valid_IF_ID <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            redir_pc <= redir_nxt;
            // Flush and "nothing delivered" both bubble; pc4 is kept for j_tgt.
            if (IF_ID_Flush) begin
                instr_IF_ID <= NOP_INSTR;
                valid_IF_ID <= 1'b0;
            end else if (accept) begin
                instr_IF_ID <= imem_rdata;
                pc4_IF_ID   <= pc + WORD_BYTES;
                valid_IF_ID <= 1'b1;
            end else if (!holdPC) begin
                instr_IF_ID <= NOP_INSTR;
                valid_IF_ID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; accepted words are predicted into a queue and
// popped when IF/ID should present them.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        holdPC;
    logic        IF_ID_Flush;
    logic        isBranch;
    logic [31:0] PC_offset;
    logic [31:0] branch_pc4;
    logic        isJump;
    logic [25:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_IF_ID;
    logic [31:0] pc4_IF_ID;
    logic        valid_IF_ID;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_t;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .holdPC      (holdPC),
        .IF_ID_Flush (IF_ID_Flush),
        .isBranch    (isBranch),
        .PC_offset   (PC_offset),
        .branch_pc4  (branch_pc4),
        .isJump      (isJump),
        .jump_target (jump_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_IF_ID (instr_IF_ID),
        .pc4_IF_ID   (pc4_IF_ID),
        .valid_IF_ID (valid_IF_ID)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(imem_req), 32'd0);
        chk({tag, "_addr"},  imem_addr, 32'h0000_0000);
        chk({tag, "_valid"}, 32'(valid_IF_ID), 32'd0);
        chk({tag, "_instr"}, instr_IF_ID, NOP);
        chk({tag, "_pc4"},   pc4_IF_ID, 32'd0);
    endtask

    // One fetch cycle: check the request, play memory, then check IF/ID.
    task automatic cycle(input logic [31:0] exp_addr, input bit ack, input bit flush,
                         input bit hold, input bit br, input bit jmp, input bit accept);
        sb_t e;
        chk("req", 32'(imem_req), 32'd1);
        chk("addr", imem_addr, exp_addr);
        imem_ack    = ack;
        imem_rdata  = ack ? word_of(imem_addr) : 32'hDEAD_BEEF;
        IF_ID_Flush = flush;
        holdPC      = hold;
        isBranch    = br;
        isJump      = jmp;
        if (accept) begin
            e.instr = word_of(exp_addr);
            e.pc4   = exp_addr + 32'd4;
            sb_q.push_back(e);
        end
        tick();
        imem_ack    = 1'b0;
        IF_ID_Flush = 1'b0;
        holdPC      = 1'b0;
        isBranch    = 1'b0;
        isJump      = 1'b0;
        if (accept) begin
            e = sb_q.pop_front();
            chk("ifid_instr", instr_IF_ID, e.instr);
            chk("ifid_pc4", pc4_IF_ID, e.pc4);
            chk("ifid_valid", 32'(valid_IF_ID), 32'd1);
        end else if (flush || !hold) begin
            chk("ifid_bubble_valid", 32'(valid_IF_ID), 32'd0);
            chk("ifid_bubble_instr", instr_IF_ID, NOP);
        end
    endtask

    initial begin
        rst         = 1'b1;
        holdPC      = 1'b0;
        IF_ID_Flush = 1'b0;
        isBranch    = 1'b0;
        PC_offset   = 32'd0;
        branch_pc4  = 32'd0;
        isJump      = 1'b0;
        jump_target = 26'd0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        repeat (3) tick();
        chk_reset_outputs("reset");

        // IDLE keeps req low for one cycle after reset
        rst = 1'b0;
        chk("idle_req", 32'(imem_req), 32'd0);
        tick();

        // zero-wait memory: one word per cycle
        for (int i = 0; i < 5; i++) begin
            cycle(32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // branch while waiting: address held, late word dropped, go to 0x18
        branch_pc4 = 32'h0000_0020;
        PC_offset  = 32'hFFFF_FFFE;
        cycle(32'h14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(32'h14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(32'h18, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // branch and jump with the ack: branch wins, IF/ID bubbles
        branch_pc4  = 32'h0000_0030;
        PC_offset   = 32'h0000_0004;
        jump_target = 26'h40;
        cycle(32'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // jump alone with the ack lands on 0x10
        jump_target = 26'h4;
        cycle(32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // hold+flush at 0x10: bubble with pc4 kept, then refetch 0x10
        cycle(32'h10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush_pc4_kept", pc4_IF_ID, 32'h44);
        cycle(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // hold alone: IF/ID keeps the word from 0x10, 0x14 refetched
        cycle(32'h14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("hold_instr", instr_IF_ID, word_of(32'h10));
        chk("hold_pc4", pc4_IF_ID, 32'h14);
        chk("hold_valid", 32'(valid_IF_ID), 32'd1);

        // two redirects while killing: the newest (jump to 0xC0) wins
        branch_pc4  = 32'h0000_0100;
        PC_offset   = 32'h0000_0000;
        jump_target = 26'h30;
        cycle(32'h14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(32'h14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(32'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset with a request outstanding and its ack arriving during reset
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = word_of(32'hC0);
        tick();
        imem_ack = 1'b0;
        chk_reset_outputs("rst_mid");
        rst = 1'b0;
        chk("rst_mid_idle_req", 32'(imem_req), 32'd0);
        tick();
        cycle(32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(32'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
